pmem_arbiter: RTL
=================

Name: pmem_arbiter

Overview:
- Shares a single physical-memory port between the instruction cache and the data cache; each cache's miss/write-back controller issues line-sized read/write requests.
- Sits between the two cache_control/datapath pairs and physical memory.
- Grants one requester at a time and latches that requester's command, address and write data for the whole transaction.
- Routes the memory response and read data back to the granted requester only.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate grant on simultaneous requests; 0 = fixed priority, data cache always wins ties.
- ADDR_W, 16, byte address width (lc3b_word).
- LINE_W, 128, cache line width in bits (16-byte lines).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_pmem_read  in  1  icache line read request; held until i_pmem_resp.
- i_pmem_write  in  1  icache line write request; held until i_pmem_resp.
- i_pmem_address  in  ADDR_W  icache line address; bits [3:0] are ignored and forced to 0.
- i_pmem_wdata  in  LINE_W  icache write line.
- i_pmem_rdata  out  LINE_W  read line to icache.
- i_pmem_resp  out  1  one-cycle completion pulse to icache.
- d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata, d_pmem_rdata, d_pmem_resp: same as the i_ ports, for the dcache.
- pmem_read  out  1  read command to memory.
- pmem_write  out  1  write command to memory.
- pmem_address  out  ADDR_W  latched line address.
- pmem_wdata  out  LINE_W  latched write line.
- pmem_rdata  in  LINE_W  memory read line.
- pmem_resp  in  1  memory completion.
- grant  out  2  2'b00 none, 2'b01 icache, 2'b10 dcache.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state = IDLE; all outputs 0; latches cleared; last_grant = icache, so the first tie in round-robin mode goes to the dcache.
- States:
  - IDLE: no memory command.
  - SERVE_I: icache owns memory.
  - SERVE_D: dcache owns memory.
- Request definition: req_x = x_pmem_read | x_pmem_write. If both read and write are asserted, the transaction is a write.
- IDLE -> SERVE_x:
  - Only one requester active: grant it.
  - Both active, ROUND_ROBIN=1: grant the one not equal to last_grant.
  - Both active, ROUND_ROBIN=0: grant the dcache.
  - On the grant edge, latch op, {address[15:4], 4'b0}, wdata; update last_grant.
- SERVE_x:
  - pmem_read/pmem_write are driven from the latched op; pmem_address/pmem_wdata from the latches; grant shows the owner.
  - Commands are held until pmem_resp is sampled high.
  - In the pmem_resp cycle, x_pmem_resp = 1 and x_pmem_rdata = pmem_rdata (combinational pass-through); next state IDLE.
  - The non-granted requester sees resp = 0 and rdata = 0 throughout.
- Latency:
  - Request seen in cycle N -> pmem command asserted from cycle N+1.
  - Memory resp in cycle M -> requester resp in cycle M.
  - Arbiter is back in IDLE at M+1 and can grant at the M+1 edge, i.e. command at M+2.
  - Minimum one idle cycle between transactions.
- Changes during a transaction: requester changing or dropping its signals mid-transaction has no effect; the latched transaction completes and the resp pulse is still issued.
- pmem_resp outside SERVE: ignored, no client resp.
- Write-back then read (dcache dirty miss): two separate transactions. A pending icache request may be granted between them under round-robin; under fixed priority the dcache re-wins only if its read is asserted in the IDLE cycle.
- Reset mid-transaction: abort immediately to IDLE with all outputs 0. The memory side must also be reset.
- No starvation under ROUND_ROBIN=1: a waiting requester is granted within one transaction of the other.

Test Plan:
- icache read alone, address 16'h1234, memory resp after 3 cycles with rdata 128'hA5…:
  - pmem_address = 16'h1230 and pmem_read from the cycle after the request;
  - i_pmem_resp for exactly 1 cycle with rdata A5…;
  - d_pmem_resp stays 0.
- Simultaneous i read 16'h0040 and d write 16'h8000 (wdata 128'hDEAD…), ROUND_ROBIN=1 after reset:
  - dcache is served first (pmem_write, address 8000, wdata latched);
  - icache is granted the cycle after the dresp cycle + 1.
- Same stimulus with ROUND_ROBIN=0 and dcache re-requesting continuously:
  - dcache wins every tie; icache served only when d_pmem_read/write are 0 in IDLE.
- dcache changes d_pmem_address from 16'h8000 to 16'h9000 and drops write mid-transaction:
  - pmem_address stays 16'h8000 and pmem_write stays 1 until pmem_resp.
- reset_n pulsed low during SERVE_D:
  - all outputs 0 asynchronously; grant = 0; after release, a new icache request is granted normally.
- Spurious pmem_resp in IDLE:
  - no client resp; state stays IDLE.

Source files
------------

// File: rtl/pmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter
//  Description : Shares one physical-memory port between the instruction
//                cache and the data cache. One requester is granted at a
//                time. Its command, line-aligned address and write line are
//                latched for the whole transaction. The memory response and
//                read line are routed back only to the granted requester.
//
//  Ports
//    clk            in   system clock, rising edge
//    reset_n        in   asynchronous active-low reset
//    i_pmem_read    in   icache line read request (held until i_pmem_resp)
//    i_pmem_write   in   icache line write request (held until i_pmem_resp)
//    i_pmem_address in   icache line address (low offset bits ignored)
//    i_pmem_wdata   in   icache write line
//    i_pmem_rdata   out  read line to icache (zero unless responding)
//    i_pmem_resp    out  one-cycle completion pulse to icache
//    d_pmem_*            same set of signals for the dcache
//    pmem_read      out  read command to memory
//    pmem_write     out  write command to memory
//    pmem_address   out  latched line address
//    pmem_wdata     out  latched write line
//    pmem_rdata     in   memory read line
//    pmem_resp      in   memory completion
//    grant          out  owner: 2'b00 none, 2'b01 icache, 2'b10 dcache
//
//  Revision    : 1.0  initial release
// ============================================================================
module pmem_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 128
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic [1:0]        grant
);

    // Number of byte-offset bits inside one line; these are zeroed on latch.
    localparam int c_OFFSET_W = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_last_d;      // 1: dcache was granted last
    logic                r_op_write;    // latched operation, 1 = write
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_wdata;

    logic                w_req_i;
    logic                w_req_d;
    logic                w_tie_to_d;
    logic                w_take_i;
    logic                w_take_d;
    logic [ADDR_W-1:0]   w_i_line_addr;
    logic [ADDR_W-1:0]   w_d_line_addr;
    logic                w_unused_offset;

    // ------------------------------------------------------------------
    // Request decode and line alignment
    // ------------------------------------------------------------------
    assign w_req_i = i_pmem_read | i_pmem_write;
    assign w_req_d = d_pmem_read | d_pmem_write;

    assign w_i_line_addr = {i_pmem_address[ADDR_W-1:c_OFFSET_W], {c_OFFSET_W{1'b0}}};
    assign w_d_line_addr = {d_pmem_address[ADDR_W-1:c_OFFSET_W], {c_OFFSET_W{1'b0}}};

    // Offset bits are deliberately dropped; fold them into a sink.
    assign w_unused_offset = ^{i_pmem_address[c_OFFSET_W-1:0],
                               d_pmem_address[c_OFFSET_W-1:0]};

    // ------------------------------------------------------------------
    // Tie-break policy when both caches request in the same IDLE cycle
    // ------------------------------------------------------------------
    generate
        if (ROUND_ROBIN != 0) begin : g_round_robin
            // Favour whoever was not served last.
            assign w_tie_to_d = ~r_last_d;
        end else begin : g_fixed_priority
            // Data cache always wins a tie.
            assign w_tie_to_d = 1'b1;
        end
    endgenerate

    assign w_take_d = w_req_d & (~w_req_i | w_tie_to_d);
    assign w_take_i = w_req_i & ~w_take_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_take_d) begin
                    w_next_state = SERVE_D;
                end else if (w_take_i) begin
                    w_next_state = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction latches: captured only on the grant edge, so requester
    // changes while a transaction is in flight have no effect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_d   <= 1'b0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (r_state == IDLE) begin
            if (w_take_d) begin
                r_last_d   <= 1'b1;
                r_op_write <= d_pmem_write;   // write wins if both asserted
                r_addr     <= w_d_line_addr;
                r_wdata    <= d_pmem_wdata;
            end else if (w_take_i) begin
                r_last_d   <= 1'b0;
                r_op_write <= i_pmem_write;
                r_addr     <= w_i_line_addr;
                r_wdata    <= i_pmem_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Everything is zero outside a SERVE state, so a stray
    // pmem_resp while idle never reaches a client.
    // ------------------------------------------------------------------
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        grant        = 2'b00;
        i_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        case (r_state)
            SERVE_I: begin
                pmem_read    = ~r_op_write;
                pmem_write   = r_op_write;
                pmem_address = r_addr;
                pmem_wdata   = r_wdata;
                grant        = 2'b01;
                i_pmem_resp  = pmem_resp;
                i_pmem_rdata = pmem_resp ? pmem_rdata : '0;
            end
            SERVE_D: begin
                pmem_read    = ~r_op_write;
                pmem_write   = r_op_write;
                pmem_address = r_addr;
                pmem_wdata   = r_wdata;
                grant        = 2'b10;
                d_pmem_resp  = pmem_resp;
                d_pmem_rdata = pmem_resp ? pmem_rdata : '0;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
